// File: rtl/dmem_bank_pkg.sv
// dmem_bank_pkg: shared defaults, FSM encodings and lane parity helper for dmem_bank
package dmem_bank_pkg;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH = 2048;
  localparam logic S_CLEAR = 1'b0;
  localparam logic S_RUN = 1'b1;
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/dmem_bank_ram.sv
// dmem_bank_ram: byte-strobed sync-read RAM, no reset; per-lane parity column when DMEM_BANK_PARITY_EN is defined
module dmem_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wpar,
  output logic [DATA_W-1:0]        rdata,
  output logic [DATA_W/8-1:0]      rpar
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++)
          if (be[i]) mem[idx][8*i+:8] <= wdata[8*i+:8];
      end else rdata <= mem[idx];
    end
`ifdef DMEM_BANK_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++)
          if (be[i]) par[idx][i] <= wpar[i];
      end else rpar <= par[idx];
    end
`else
  logic unused_wpar;
  assign unused_wpar = ^wpar;
  assign rpar = '0;
`endif
endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: LSU data RAM with byte strobes, valid/ready handshakes and post-reset zero-fill
// Optional per-lane parity checking is enabled by defining DMEM_BANK_PARITY_EN.
module dmem_bank
  import dmem_bank_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int ADDR_W = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_par_err,
  output logic                init_done
);
  localparam int NB = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  logic st;
  logic [IDX_W-1:0] clr_idx;
  logic clearing, acc, rd, ram_en, ram_we;
  logic [NB-1:0] ram_be, wpar, rpar;
  logic [IDX_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_wdata, rdata;
  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
  always_comb begin
    clearing = st == S_CLEAR;
    req_ready = ~clearing & (~rsp_valid | rsp_ready);
    acc = req_valid & req_ready;
    rd = acc & ~req_we;
    ram_en = clearing | acc;
    ram_we = clearing | req_we;
    ram_be = clearing ? '1 : req_be;
    ram_idx = clearing ? clr_idx : req_addr[IDX_W+1:2];
    ram_wdata = clearing ? '0 : req_wdata;
  end
  for (genvar g = 0; g < NB; g++) begin : g_wpar
    assign wpar[g] = byte_par(ram_wdata[8*g+:8]);
  end
  dmem_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .be(ram_be), .idx(ram_idx),
    .wdata(ram_wdata), .wpar(wpar), .rdata(rdata), .rpar(rpar)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_RUN;
      clr_idx <= '0;
      init_done <= CLEAR_ON_RESET == 0;
      rsp_valid <= 1'b0;
    end else if (clearing) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == IDX_W'(DEPTH - 1)) begin
        st <= S_RUN;
        init_done <= 1'b1;
      end
    end else rsp_valid <= rd | (rsp_valid & ~rsp_ready);
  // RAM output only changes on a read accept, so it doubles as the held response register
  assign rsp_rdata = rsp_valid ? rdata : '0;
`ifdef DMEM_BANK_PARITY_EN
  logic [NB-1:0] cpar;
  for (genvar g = 0; g < NB; g++) begin : g_cpar
    assign cpar[g] = byte_par(rdata[8*g+:8]);
  end
  assign rsp_par_err = rsp_valid & |(cpar ^ rpar);
`else
  logic unused_rpar;
  assign unused_rpar = ^rpar;
  assign rsp_par_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: scoreboard bench for dmem_bank with a reduced DEPTH to keep the zero-fill short
module tb_dmem_bank;
  localparam int DEPTH = 64;
  logic clk = 0, reset = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_par_err, init_done;
  logic [31:0] rsp_rdata;
  typedef struct {logic [31:0] d; logic p; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0, first = 0;
  logic held = 0;

  dmem_bank #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_par_err(rsp_par_err), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid && !held) first = cyc;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'(q.size()), 1);
      else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_par_err", 32'(rsp_par_err), 32'(e.p));
        chk("rsp_latency", first, e.c);
      end
    end
    held = rsp_valid && !rsp_ready;
  end

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] ed, input logic ep);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_accept", 32'(req_ready), 1);
    if (req_ready && !we) q.push_back('{ed, ep, cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req(1, a, d, be, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ep);
    req(0, a, 0, 0, ed, ep);
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("drain", 32'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic fill();
    int n = 0;
    logic seen = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    while (!init_done && n < 4 * DEPTH) begin
      if (req_ready) seen = 1;
      @(posedge clk); #1;
      n++;
    end
    chk("fill_cycles", n, DEPTH);
    chk("ready_during_fill", 32'(seen), 0);
    chk("init_done", 32'(init_done), 1);
    chk("ready_after_fill", 32'(req_ready), 1);
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_par_err", 32'(rsp_par_err), 0);
    chk("rst_init_done", 32'(init_done), 0);
    fill();
    rd(32'h0, 0, 0);
    rd(32'((DEPTH - 1) * 4), 0, 0);
    idle(); drain();
    // byte strobes and a zero-strobe no-op write
    wr(32'h40, 32'hAABBCCDD, 4'b1111);
    wr(32'h40, 32'h00000011, 4'b0001);
    rd(32'h40, 32'hAABBCC11, 0);
    wr(32'h40, 32'hFFFFFFFF, 4'b0000);
    wr(32'h40, 32'h99000000, 4'b1000);
    rd(32'h40, 32'h99BBCC11, 0);
    idle(); drain();
    // back-to-back reads at full rate
    wr(32'h0, 32'h55556666, 4'hF);
    wr(32'h4, 32'h11112222, 4'hF);
    wr(32'h8, 32'h33334444, 4'hF);
    rd(32'h0, 32'h55556666, 0);
    rd(32'h4, 32'h11112222, 0);
    rd(32'h8, 32'h33334444, 0);
    idle(); drain();
    // backpressure
    rsp_ready = 0;
    rd(32'h4, 32'h11112222, 0);
    idle();
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_rdata", rsp_rdata, 32'h11112222);
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    #1 chk("take_req_ready", 32'(req_ready), 1);
    drain();
    // index wrap and ignored low address bits
    wr(32'(DEPTH * 4 + 8), 32'h5, 4'hF);
    rd(32'h8, 32'h5, 0);
    rd(32'hB, 32'h5, 0);
    idle(); drain();
    // reset during a stalled response
    rsp_ready = 0;
    rd(32'h8, 32'h5, 0);
    idle();
    @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_init_done", 32'(init_done), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    q.delete();
    rsp_ready = 1;
    fill();
    rd(32'h8, 0, 0);
    rd(32'h40, 0, 0);
    idle(); drain();
`ifdef DMEM_BANK_PARITY_EN
    wr(32'h8, 32'h000000F0, 4'hF);
    idle();
    u_dut.u_ram.mem[2][3] = ~u_dut.u_ram.mem[2][3];
    rd(32'h8, 32'h000000F8, 1);
    rd(32'h0, 0, 0);
    idle(); drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
